// File: rtl/acc_drain_pkg.sv
// ---------------------------------------------------------------------------
// acc_drain_pkg
// Shared definitions for the accumulator drain / requantize block:
//   - state_t       : FSM state encoding (IDLE, RUN, DRAIN)
//   - DEF_*         : default lane widths and vector-count width
// ---------------------------------------------------------------------------
package acc_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_BLOCK_OUT = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/acc_drain_if.sv
// ---------------------------------------------------------------------------
// acc_drain_if
// Groups the two streaming handshakes of acc_drain.
//   acc_valid / acc_ready / acc_data : MAC sum stream into the block
//   out_valid / out_ready / out_data : requantized stream out of the block
// Lane i of a vector occupies bits [i*W +: W] of the data bus.
//
// Handshake rule (both streams): a beat transfers on a rising clk edge when
// valid and ready are both high. A source holding valid high keeps its data
// stable until the beat transfers; ready may depend combinationally on the
// sink's downstream state but never on valid.
//
// Modports:
//   master : upstream producer / downstream consumer side (testbench)
//   slave  : the acc_drain block itself
// ---------------------------------------------------------------------------
interface acc_drain_if
  import acc_drain_pkg::*;
#(
  parameter int BLOCK_OUT = DEF_BLOCK_OUT,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

  logic                           acc_valid;
  logic                           acc_ready;
  logic [BLOCK_OUT*ACC_WIDTH-1:0] acc_data;

  logic                           out_valid;
  logic                           out_ready;
  logic [BLOCK_OUT*OUT_WIDTH-1:0] out_data;

  modport master (
    output acc_valid, acc_data, out_ready,
    input  acc_ready, out_valid, out_data
  );

  modport slave (
    input  acc_valid, acc_data, out_ready,
    output acc_ready, out_valid, out_data
  );

endinterface

// File: rtl/acc_requant_lane.sv
// ---------------------------------------------------------------------------
// acc_requant_lane
// Combinational per-lane requantization, split so each half feeds one
// pipeline register in the parent:
//   i_acc, i_shift -> o_shr : arithmetic right shift (floor, sign kept)
//   i_shr          -> o_sat : saturating clip to the signed OUT_WIDTH range
// Ports:
//   i_acc   [ACC_WIDTH] signed accumulator lane
//   i_shift [5]         shift amount 0..31
//   o_shr   [ACC_WIDTH] shifted lane (to stage-1 register)
//   i_shr   [ACC_WIDTH] registered shifted lane (from stage-1 register)
//   o_sat   [OUT_WIDTH] clipped lane (to stage-2 register)
// ---------------------------------------------------------------------------
module acc_requant_lane #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic        [4:0]           i_shift,
  output logic signed [ACC_WIDTH-1:0] o_shr,
  input  logic signed [ACC_WIDTH-1:0] i_shr,
  output logic signed [OUT_WIDTH-1:0] o_sat
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  // Two's complement: -(max) - 1 == ~max
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // >>> on a signed operand replicates the sign bit, which is exactly
  // truncation toward negative infinity.
  assign o_shr = i_acc >>> i_shift;

  always_comb begin
    o_sat = i_shr[OUT_WIDTH-1:0];
    if (i_shr > SAT_MAX) begin
      o_sat = SAT_MAX[OUT_WIDTH-1:0];
    end else if (i_shr < SAT_MIN) begin
      o_sat = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/acc_drain.sv
// ---------------------------------------------------------------------------
// acc_drain
// Drains a job of num_vec accumulator vectors, requantizing each lane with
// an arithmetic right shift followed by a saturating clip, through a
// two-stage elastic pipeline.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle job launch (honoured only in IDLE)
//   num_vec [CNT]     vectors in the job, sampled with start
//   shift   [5]       right-shift amount, sampled with start
//   bus (slave)       acc_* input stream and out_* output stream
//   busy              high while the FSM is not IDLE
//   done              one-cycle pulse at job completion
//   dbg_state         current FSM state
// ---------------------------------------------------------------------------
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int BLOCK_OUT = DEF_BLOCK_OUT,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vec,
  input  logic [4:0]           shift,
  acc_drain_if.slave           bus,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  localparam int AB = BLOCK_OUT * ACC_WIDTH;
  localparam int OB = BLOCK_OUT * OUT_WIDTH;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_num_vec;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [4:0]           r_shift;
  logic                 r_done;

  logic                 r_s1_valid;
  logic [AB-1:0]        r_s1_data;
  logic                 r_s2_valid;
  logic [OB-1:0]        r_s2_data;

  logic [AB-1:0]        w_shr;
  logic [OB-1:0]        w_sat;
  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_acc_xfer;
  logic                 w_out_xfer;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // A stage may load when it is empty or its content is leaving this cycle.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign bus.acc_ready = (r_state == ST_RUN) && w_s1_adv;
  assign w_acc_xfer = bus.acc_valid && bus.acc_ready;
  assign w_out_xfer = r_s2_valid && bus.out_ready;
  assign w_cnt_nxt  = r_cnt + CNT_WIDTH'(1);

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign dbg_state     = r_state;

  for (genvar g = 0; g < BLOCK_OUT; g++) begin : g_lane
    acc_requant_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .i_acc   (bus.acc_data[g*ACC_WIDTH +: ACC_WIDTH]),
      .i_shift (r_shift),
      .o_shr   (w_shr[g*ACC_WIDTH +: ACC_WIDTH]),
      .i_shr   (r_s1_data[g*ACC_WIDTH +: ACC_WIDTH]),
      .o_sat   (w_sat[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Job control FSM. done is registered, so it rises together with the
  // return to IDLE (or one cycle after an empty-job start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_num_vec <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_vec <= num_vec;
            r_shift   <= shift;
            r_cnt     <= '0;
            if (num_vec == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_acc_xfer) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_num_vec) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Once stage 1 is empty in DRAIN, stage 2 holds the final beat.
          if (w_out_xfer && !r_s1_valid) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage elastic pipeline: stage 1 = shifted lanes, stage 2 = clipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_sat;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_acc_xfer;
        if (w_acc_xfer) begin
          r_s1_data <= w_shr;
        end
      end
    end
  end

endmodule
